// File: rtl/mux_4_to_1_arb.sv
// mux_4_to_1_arb: registered 4-to-1 valid/ready stream merge with round-robin
// arbitration and a single output register stage.
// Optional packet locking (i_last_n / o_last) is enabled by defining the
// macro MUX_4_TO_1_ARB_LAST_EN.
module mux_4_to_1_arb #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data_1,
  input  logic [WIDTH-1:0] i_data_2,
  input  logic [WIDTH-1:0] i_data_3,
  input  logic [WIDTH-1:0] i_data_4,
  input  logic             i_valid_1,
  input  logic             i_valid_2,
  input  logic             i_valid_3,
  input  logic             i_valid_4,
  output logic             o_ready_1,
  output logic             o_ready_2,
  output logic             o_ready_3,
  output logic             o_ready_4,
`ifdef MUX_4_TO_1_ARB_LAST_EN
  input  logic             i_last_1,
  input  logic             i_last_2,
  input  logic             i_last_3,
  input  logic             i_last_4,
  output logic             o_last,
`endif
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sel_1,
  output logic             o_sel_2
);

  localparam int unsigned CH_N  = 4;
  localparam int unsigned SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_CH4 = SEL_W'(3);

  logic [WIDTH-1:0] w_data [CH_N];
  logic [CH_N-1:0]  w_valid;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_found;
  logic             w_load;
  logic             w_accept;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_last_grant;

`ifdef MUX_4_TO_1_ARB_LAST_EN
  logic [CH_N-1:0]  w_last;
  logic             r_lock;
  logic             r_last;

  assign w_last = {i_last_4, i_last_3, i_last_2, i_last_1};
`endif

  assign w_data[0] = i_data_1;
  assign w_data[1] = i_data_2;
  assign w_data[2] = i_data_3;
  assign w_data[3] = i_data_4;
  assign w_valid   = {i_valid_4, i_valid_3, i_valid_2, i_valid_1};

  // Round-robin pick: first valid channel starting after the last grant.
  always_comb begin : arb
    logic [SEL_W-1:0] idx;
    w_found     = 1'b0;
    w_grant_idx = r_last_grant;
    idx         = r_last_grant;
    for (int i = 1; i <= int'(CH_N); i++) begin
      idx = r_last_grant + SEL_W'(i);
      if (!w_found && w_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_idx = idx;
      end
    end
`ifdef MUX_4_TO_1_ARB_LAST_EN
    // Mid-packet: only the locked channel may be served, even when idle.
    if (r_lock) begin
      w_grant_idx = r_last_grant;
      w_found     = w_valid[r_last_grant];
    end
`endif
  end

  assign w_load   = !r_valid || i_ready;
  assign w_accept = w_load && w_found && i_rst_n;

  // Ready back to the single granted source; held low while in reset.
  always_comb begin
    o_ready_1 = 1'b0;
    o_ready_2 = 1'b0;
    o_ready_3 = 1'b0;
    o_ready_4 = 1'b0;
    if (w_accept) begin
      case (w_grant_idx)
        SEL_W'(0): o_ready_1 = 1'b1;
        SEL_W'(1): o_ready_2 = 1'b1;
        SEL_W'(2): o_ready_3 = 1'b1;
        default:   o_ready_4 = 1'b1;
      endcase
    end
  end

  // Output register stage and arbitration pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_sel        <= '0;
      r_last_grant <= SEL_CH4;
`ifdef MUX_4_TO_1_ARB_LAST_EN
      r_lock       <= 1'b0;
      r_last       <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_found) begin
        r_data       <= w_data[w_grant_idx];
        r_valid      <= 1'b1;
        r_sel        <= w_grant_idx;
        r_last_grant <= w_grant_idx;
`ifdef MUX_4_TO_1_ARB_LAST_EN
        r_last       <= w_last[w_grant_idx];
        r_lock       <= !w_last[w_grant_idx];
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_sel_1 = r_sel[1];
  assign o_sel_2 = r_sel[0];
`ifdef MUX_4_TO_1_ARB_LAST_EN
  assign o_last  = r_last;
`endif

endmodule

// File: tb/tb_mux_4_to_1_arb.sv
// Directed, table-driven bench for mux_4_to_1_arb.
module tb_mux_4_to_1_arb;

  logic       i_clk;
  logic       i_rst_n;
  logic [7:0] i_data_1, i_data_2, i_data_3, i_data_4;
  logic       i_valid_1, i_valid_2, i_valid_3, i_valid_4;
  logic       o_ready_1, o_ready_2, o_ready_3, o_ready_4;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_sel_1, o_sel_2;
`ifdef MUX_4_TO_1_ARB_LAST_EN
  logic       i_last_1, i_last_2, i_last_3, i_last_4;
  logic       o_last;
`endif

  int total = 0;
  int bad   = 0;

  mux_4_to_1_arb #(.WIDTH(8)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data_1  (i_data_1),
    .i_data_2  (i_data_2),
    .i_data_3  (i_data_3),
    .i_data_4  (i_data_4),
    .i_valid_1 (i_valid_1),
    .i_valid_2 (i_valid_2),
    .i_valid_3 (i_valid_3),
    .i_valid_4 (i_valid_4),
    .o_ready_1 (o_ready_1),
    .o_ready_2 (o_ready_2),
    .o_ready_3 (o_ready_3),
    .o_ready_4 (o_ready_4),
`ifdef MUX_4_TO_1_ARB_LAST_EN
    .i_last_1  (i_last_1),
    .i_last_2  (i_last_2),
    .i_last_3  (i_last_3),
    .i_last_4  (i_last_4),
    .o_last    (o_last),
`endif
    .o_data    (o_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_sel_1   (o_sel_1),
    .o_sel_2   (o_sel_2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [3:0]  valid;     // {v4,v3,v2,v1}
    logic        rdy;
    logic [31:0] data;      // {d4,d3,d2,d1}
    logic [3:0]  exp_rdy;   // {r4,r3,r2,r1}, checked before the edge
    logic        exp_valid; // registered outputs after the edge
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rdy_vec();
    return {o_ready_4, o_ready_3, o_ready_2, o_ready_1};
  endfunction

  task automatic drive(input logic [3:0] v, input logic rdy, input logic [31:0] d);
    {i_valid_4, i_valid_3, i_valid_2, i_valid_1} = v;
    {i_data_4, i_data_3, i_data_2, i_data_1}     = d;
    i_ready = rdy;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed, input logic [1:0] es);
    chk({tag, ".valid"}, 32'(o_valid), 32'(ev));
    chk({tag, ".data"},  32'(o_data),  32'(ed));
    chk({tag, ".sel"},   32'({o_sel_1, o_sel_2}), 32'(es));
  endtask

  initial begin
    // Sequential vectors; state carries from one row to the next.
    vecs[0]  = '{4'hF, 1'b1, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0};
    vecs[1]  = '{4'hF, 1'b1, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1};
    vecs[2]  = '{4'hF, 1'b1, 32'h44332211, 4'h4, 1'b1, 8'h33, 2'd2};
    vecs[3]  = '{4'hF, 1'b1, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3};
    vecs[4]  = '{4'hF, 1'b1, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0};
    vecs[5]  = '{4'hF, 1'b0, 32'h44332211, 4'h0, 1'b1, 8'h11, 2'd0};
    vecs[6]  = '{4'hF, 1'b0, 32'h44332211, 4'h0, 1'b1, 8'h11, 2'd0};
    vecs[7]  = '{4'hF, 1'b0, 32'h44332211, 4'h0, 1'b1, 8'h11, 2'd0};
    vecs[8]  = '{4'hF, 1'b0, 32'h44332211, 4'h0, 1'b1, 8'h11, 2'd0};
    vecs[9]  = '{4'hF, 1'b0, 32'h44332211, 4'h0, 1'b1, 8'h11, 2'd0};
    vecs[10] = '{4'hF, 1'b1, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1};
    vecs[11] = '{4'hA, 1'b1, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3};
    vecs[12] = '{4'hA, 1'b1, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1};
    vecs[13] = '{4'hA, 1'b1, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3};
    vecs[14] = '{4'hA, 1'b1, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1};
    vecs[15] = '{4'h0, 1'b1, 32'h44332211, 4'h0, 1'b0, 8'h22, 2'd1};
    vecs[16] = '{4'h0, 1'b0, 32'h44332211, 4'h0, 1'b0, 8'h22, 2'd1};
    vecs[17] = '{4'h4, 1'b0, 32'h44A52211, 4'h4, 1'b1, 8'hA5, 2'd2};
    vecs[18] = '{4'h0, 1'b0, 32'h44A52211, 4'h0, 1'b1, 8'hA5, 2'd2};
    vecs[19] = '{4'h1, 1'b1, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0};

`ifdef MUX_4_TO_1_ARB_LAST_EN
    {i_last_4, i_last_3, i_last_2, i_last_1} = 4'hF;
`endif

    // Reset held with every source valid.
    i_rst_n = 1'b0;
    drive(4'hF, 1'b1, 32'h44332211);
    repeat (3) tick();
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.ready", 32'(rdy_vec()), 32'h0);
    i_rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].valid, vecs[i].rdy, vecs[i].data);
      #1;
      chk($sformatf("v%0d.ready", i), 32'(rdy_vec()), 32'(vecs[i].exp_rdy));
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_sel);
    end

    // Reset mid-transfer: outputs clear at once and arbitration restarts at ch1.
    drive(4'hF, 1'b1, 32'h44332211);
    tick();
    chk_out("pre_rst", 1'b1, 8'h22, 2'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 2'd0);
    chk("async_rst.ready", 32'(rdy_vec()), 32'h0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("post_rst.ready", 32'(rdy_vec()), 32'h1);
    tick();
    chk_out("post_rst", 1'b1, 8'h11, 2'd0);

`ifdef MUX_4_TO_1_ARB_LAST_EN
    // Three-beat packet on ch1 while ch2 waits; ch1 idles once mid-packet.
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    {i_last_4, i_last_3, i_last_2, i_last_1} = 4'hE;
    drive(4'h3, 1'b1, 32'h44332211);
    #1 chk("pkt1.ready", 32'(rdy_vec()), 32'h1);
    tick();
    chk_out("pkt1", 1'b1, 8'h11, 2'd0);
    chk("pkt1.last", 32'(o_last), 32'h0);
    #1 chk("pkt2.ready", 32'(rdy_vec()), 32'h1);
    tick();
    chk_out("pkt2", 1'b1, 8'h11, 2'd0);
    drive(4'h2, 1'b1, 32'h44332211);
    #1 chk("lock_idle.ready", 32'(rdy_vec()), 32'h0);
    tick();
    chk("lock_idle.valid", 32'(o_valid), 32'h0);
    i_last_1 = 1'b1;
    drive(4'h3, 1'b1, 32'h44332211);
    #1 chk("pkt3.ready", 32'(rdy_vec()), 32'h1);
    tick();
    chk_out("pkt3", 1'b1, 8'h11, 2'd0);
    chk("pkt3.last", 32'(o_last), 32'h1);
    #1 chk("ch2.ready", 32'(rdy_vec()), 32'h2);
    tick();
    chk_out("ch2", 1'b1, 8'h22, 2'd1);
`endif

    drive(4'h0, 1'b1, 32'h0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1_arb.md
# mux_4_to_1_arb

Registered 4-to-1 stream multiplexer with round-robin arbitration. It merges four valid/ready sources onto one output stream. It is the gathering counterpart of the 1-to-4 demultiplexer and reports the winning channel on the same two select lines. It sits between four producer blocks and a single consumer, giving each source fair access with one beat of latency.

## Interface

Parameters:
- WIDTH, default 8: data width of every input and of the output.

Ports:
- i_clk  input  1  system clock; all logic is rising-edge.
- i_rst_n  input  1  asynchronous active-low reset. Assertion is asynchronous; release is synchronous to i_clk.
- i_data_1..i_data_4  input  WIDTH  source data, channels 1-4.
- i_valid_1..i_valid_4  input  1  source data valid.
- o_ready_1..o_ready_4  output  1  beat accepted from that source this cycle (combinational).
- o_data  output  WIDTH  registered output data.
- o_valid  output  1  registered output valid.
- i_ready  input  1  consumer ready.
- o_sel_1  output  1  registered select MSB of the channel held in o_data.
- o_sel_2  output  1  registered select LSB of the channel held in o_data.
  - Encoding: 00 = channel 1, 01 = channel 2, 10 = channel 3, 11 = channel 4.

## Operation

- Output stage is a single register holding o_data, o_valid and o_sel_1/o_sel_2.
- load = !o_valid | i_ready. The register may take a new beat in any cycle where it is empty or being drained.
- Arbitration is combinational over i_valid_1..4.
  - Priority order starts at channel (last_grant + 1) mod 4 and wraps 4 -> 1.
  - grant_n is set for the first valid channel in that order.
- o_ready_n = load & grant_n. At most one o_ready is high per cycle.
  - o_ready never depends on i_valid of another channel in a way that grants two channels.
- When a beat is accepted (load & any valid):
  - o_data <= selected i_data.
  - o_sel <= channel code.
  - o_valid <= 1.
  - last_grant <= channel.
- When load is high and no channel is valid: o_valid <= 0. o_data and o_sel hold their values.
- When load is low: all registers hold and all o_ready are low.
- last_grant updates only on an accepted beat.
- Sources must hold i_data/i_valid stable until their o_ready is seen. The block does not require this for correctness; an unselected source's data is simply ignored.

## Timing

- Reset values:
  - o_valid = 0, o_data = 0, o_sel_1 = 0, o_sel_2 = 0, all o_ready = 0.
  - last_grant = channel 4, so channel 1 has first priority.
- Latency: source beat accepted on edge N appears on o_data/o_valid after edge N, i.e. visible in cycle N+1.
- Throughput: one beat per cycle while i_ready stays high.
- Back-pressure: with o_valid = 1 and i_ready = 0, every o_ready is 0 and the output holds stable.
- Simultaneous drain and load: with i_ready = 1 and o_valid = 1, the old beat leaves and the new beat loads in the same edge, with no bubble.
- Fairness: with all four sources continuously valid, grants cycle 1,2,3,4,1,… and each channel waits at most 3 accepted beats.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously). An in-flight beat is dropped and last_grant returns to 4.

## Configuration

- Macro: MUX_4_TO_1_ARB_LAST_EN.
- Defined:
  - Adds ports i_last_1..i_last_4 (input, 1 bit) and o_last (output, 1 bit, registered, reset 0).
  - After a beat is accepted from channel k with i_last_k = 0, the grant locks to channel k.
  - While locked, other channels get o_ready = 0 even if channel k is idle.
  - The lock releases after a beat from k with i_last_k = 1 is accepted; round-robin then resumes from k+1.
  - o_last carries the accepted i_last.
- Undefined: no last ports; arbitration runs fresh on every beat as described above.

## Test plan

- Reset check: hold i_rst_n = 0 with all i_valid = 1 -> o_valid = 0, o_data = 0, o_sel = 00, all o_ready = 0. After release, the first grant goes to channel 1.
- Single source: only i_valid_3 = 1, i_data_3 = 8'hA5, i_ready = 1 -> o_ready_3 high. The next cycle shows o_data = A5, o_valid = 1, o_sel_1 = 1, o_sel_2 = 0.
- Round-robin: all valid with data 11/22/33/44, i_ready = 1 -> o_data sequence 11,22,33,44,11 on consecutive cycles, with no bubbles.
- Back-pressure: i_ready = 0 for 5 cycles with o_valid = 1 -> o_data stable and all o_ready = 0. When i_ready returns to 1, the next channel in rotation is granted.
- Skip idle channels: only channels 2 and 4 valid -> grants alternate 2,4,2,4 with o_sel 01,11.
- With MUX_4_TO_1_ARB_LAST_EN: channel 1 sends a 3-beat packet (last on the 3rd beat) while channel 2 is valid -> channel 2 is granted only after channel 1's last beat, and o_last = 1 on that beat.
